// File: rtl/mips_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mips_arb_pkg                                               |
// | Purpose  : Shared types, constants and helpers for mips_bus_arbiter.  |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

    // Avalon addresses are always presented word-aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_arb_ibuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mips_arb_ibuf                                              |
// | Purpose  : One-entry instruction buffer (word tag + valid bit).       |
// |            Only compiled when MIPS_ARB_IBUF_EN is defined; the data   |
// |            word itself lives in the arbiter's instr_readdata register.|
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`ifdef MIPS_ARB_IBUF_EN
module mips_arb_ibuf (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lookup_word_i,  // word address of the fetch being requested
    output logic        hit_o,
    input  logic        fill_i,         // an instruction fetch completed on the bus
    input  logic [29:0] fill_word_i,
    input  logic        inval_wr_i,     // a data write completed on the bus
    input  logic [29:0] inval_word_i,
    input  logic        flush_i         // bus timeout: drop the entry unconditionally
);
    logic [29:0] tag_q;
    logic        valid_q;

    assign hit_o = valid_q && (tag_q == lookup_word_i);

    // Tag/valid update: invalidation takes precedence over a fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush_i || (inval_wr_i && valid_q && (inval_word_i == tag_q))) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            tag_q   <= fill_word_i;
            valid_q <= 1'b1;
        end
    end
endmodule
`endif
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mips_bus_arbiter                                           |
// | Purpose  : Shares one Avalon-MM master between the Harvard CPU's      |
// |            instruction and data ports, stalling the CPU through       |
// |            clk_enable until all accesses of a CPU cycle are complete. |
// |            Define MIPS_ARB_IBUF_EN for a one-entry instruction buffer.|
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mips_bus_arbiter
    import mips_arb_pkg::*;
#(
    parameter int DATA_FIRST = 0,   // 1: data access issued before the fetch
    parameter int MAX_WAIT   = 0    // waitrequest timeout in cycles, 0 = none (max 65535)
) (
    input  logic        clk,
    input  logic        rst,
    output logic        clk_enable,
    output logic        bus_error,
    input  logic        instr_read,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);
    arb_state_t  state_q, state_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d, write_q, write_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        clk_enable_q, clk_enable_d;
    logic        bus_error_q, bus_error_d;
    logic [31:0] instr_rdata_q, instr_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic [15:0] cnt_q, cnt_d;
    // Requests captured in IDLE; inputs are ignored for the rest of the cycle.
    logic        pend_i_q, pend_i_d, pend_d_q, pend_d_d;
    logic [31:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d, d_wdata_q, d_wdata_d;
    logic [3:0]  d_be_q, d_be_d;
    logic        d_rd_q, d_rd_d, d_wr_q, d_wr_d;

    logic        w_launch;
    arb_state_t  w_next;
    logic        w_timeout;
    logic [15:0] w_cnt_inc;
    logic        w_ibuf_hit;

`ifdef MIPS_ARB_IBUF_EN
    mips_arb_ibuf u_ibuf (
        .clk          (clk),
        .rst          (rst),
        .lookup_word_i(instr_address[31:2]),
        .hit_o        (w_ibuf_hit),
        .fill_i       (state_q == INSTR && !waitrequest),
        .fill_word_i  (i_addr_q[31:2]),
        .inval_wr_i   (state_q == DATA && !waitrequest && d_wr_q),
        .inval_word_i (d_addr_q[31:2]),
        .flush_i      (w_timeout)
    );
`else
    assign w_ibuf_hit = 1'b0;
`endif

    // Choose the next access from the pending flags in the configured order.
    function automatic arb_state_t pick(input logic pi, input logic pd);
        if (!pi && !pd)
            return DONE;
        else if (DATA_FIRST != 0)
            return pd ? DATA : INSTR;
        else
            return pi ? INSTR : DATA;
    endfunction

    assign w_cnt_inc = cnt_q + 16'd1;

    // Next-state logic: sequencing, Avalon handshake, timeout and output loading.
    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        read_d        = read_q;
        write_d       = write_q;
        writedata_d   = writedata_q;
        byteenable_d  = byteenable_q;
        clk_enable_d  = 1'b0;
        bus_error_d   = bus_error_q;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;
        cnt_d         = cnt_q;
        pend_i_d      = pend_i_q;
        pend_d_d      = pend_d_q;
        i_addr_d      = i_addr_q;
        d_addr_d      = d_addr_q;
        d_wdata_d     = d_wdata_q;
        d_be_d        = d_be_q;
        d_rd_d        = d_rd_q;
        d_wr_d        = d_wr_q;
        w_launch      = 1'b0;
        w_next        = DONE;
        w_timeout     = 1'b0;

        case (state_q)
            IDLE: begin
                i_addr_d  = instr_address;
                d_addr_d  = data_address;
                d_wdata_d = data_writedata;
                d_be_d    = data_byteenable;
                d_rd_d    = data_read;
                d_wr_d    = data_write;
                pend_i_d  = instr_read && !w_ibuf_hit;
                pend_d_d  = data_read || data_write;
                w_launch  = 1'b1;
                w_next    = pick(pend_i_d, pend_d_d);
            end
            INSTR, DATA: begin
                if (!waitrequest) begin
                    if (state_q == INSTR)
                        instr_rdata_d = readdata;
                    else if (d_rd_q && !d_wr_q)
                        data_rdata_d = readdata;
                    w_launch = 1'b1;
                    w_next   = pick(pend_i_q, pend_d_q);
                end else if ((MAX_WAIT != 0) && (w_cnt_inc == 16'(MAX_WAIT))) begin
                    // Abandon the whole CPU cycle; the CPU still gets its pulse.
                    w_timeout   = 1'b1;
                    bus_error_d = 1'b1;
                    pend_i_d    = 1'b0;
                    pend_d_d    = 1'b0;
                    w_launch    = 1'b1;
                    w_next      = DONE;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_launch) begin
            state_d = w_next;
            cnt_d   = '0;
            case (w_next)
                INSTR: begin
                    address_d    = word_align(i_addr_d);
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    byteenable_d = BE_WORD;
                    pend_i_d     = 1'b0;
                end
                DATA: begin
                    // A combined read+write performs only the write.
                    address_d    = word_align(d_addr_d);
                    read_d       = d_rd_d && !d_wr_d;
                    write_d      = d_wr_d;
                    byteenable_d = d_be_d;
                    writedata_d  = d_wdata_d;
                    pend_d_d     = 1'b0;
                end
                default: begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    clk_enable_d = 1'b1;
                end
            endcase
        end
    end

    // State and output registers; reset drops the bus strobes immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            address_q     <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            writedata_q   <= '0;
            byteenable_q  <= '0;
            clk_enable_q  <= 1'b0;
            bus_error_q   <= 1'b0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
            cnt_q         <= '0;
            pend_i_q      <= 1'b0;
            pend_d_q      <= 1'b0;
            i_addr_q      <= '0;
            d_addr_q      <= '0;
            d_wdata_q     <= '0;
            d_be_q        <= '0;
            d_rd_q        <= 1'b0;
            d_wr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            read_q        <= read_d;
            write_q       <= write_d;
            writedata_q   <= writedata_d;
            byteenable_q  <= byteenable_d;
            clk_enable_q  <= clk_enable_d;
            bus_error_q   <= bus_error_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
            cnt_q         <= cnt_d;
            pend_i_q      <= pend_i_d;
            pend_d_q      <= pend_d_d;
            i_addr_q      <= i_addr_d;
            d_addr_q      <= d_addr_d;
            d_wdata_q     <= d_wdata_d;
            d_be_q        <= d_be_d;
            d_rd_q        <= d_rd_d;
            d_wr_q        <= d_wr_d;
        end
    end

    assign clk_enable     = clk_enable_q;
    assign bus_error      = bus_error_q;
    assign instr_readdata = instr_rdata_q;
    assign data_readdata  = data_rdata_q;
    assign address        = address_q;
    assign read           = read_q;
    assign write          = write_q;
    assign writedata      = writedata_q;
    assign byteenable     = byteenable_q;

endmodule
`default_nettype wire

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single Avalon-MM master port between the Harvard CPU's instruction-fetch and data ports.
- Sequences at most one instruction read and one data access per CPU cycle.
- Stalls the CPU through clk_enable until all of that cycle's accesses complete.
- Sits between mips_cpu_harvard and the bus-level top, as a drop-in alternative to the cache controller path.

Parameters:
- DATA_FIRST, 0: 0 = instruction access before data access in a CPU cycle; 1 = data access first.
- MAX_WAIT, 0: number of consecutive waitrequest-high cycles before bus_error is raised; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clk_enable  out  1  one-cycle pulse; the CPU advances on this edge
- bus_error  out  1  sticky timeout flag, cleared only by rst
- instr_read  in  1  CPU requests an instruction fetch
- instr_address  in  32  fetch byte address
- instr_readdata  out  32  fetched word, held until the next fetch completes
- data_read  in  1  CPU data read request
- data_write  in  1  CPU data write request
- data_address  in  32  data byte address
- data_writedata  in  32  store data
- data_byteenable  in  4  store/load byte lanes
- data_readdata  out  32  loaded word, held until the next data read completes
- address  out  32  Avalon address, word-aligned
- read  out  1  Avalon read
- write  out  1  Avalon write
- writedata  out  32  Avalon write data
- byteenable  out  4  Avalon byte enables
- readdata  in  32  Avalon read data
- waitrequest  in  1  Avalon slave stall

Behaviour:
- Reset (async, rst=1): state IDLE; clk_enable, read, write, bus_error = 0; address, writedata, byteenable, instr_readdata, data_readdata, wait counter = 0.
- All Avalon outputs are registered.
- FSM states: IDLE, INSTR, DATA, DONE.
- IDLE: sample the request inputs into pending flags pi = instr_read and pd = data_read|data_write.
  - Next state: first pending access in configured order; DONE if none pending.
  - Load address, read/write, writedata and byteenable for that access on the same edge.
- Address is always driven as {addr[31:2],2'b00}.
- INSTR: byteenable = 4'b1111, read = 1.
- DATA: byteenable = data_byteenable; read = data_read & ~data_write; write = data_write.
- Simultaneous data_read and data_write: the write is performed, the read is dropped, and data_readdata is unchanged.
- Avalon handshake:
  - While waitrequest = 1, all Avalon outputs are held stable.
  - A transfer completes on the edge where waitrequest = 0.
  - readdata is captured on that same edge into instr_readdata or data_readdata.
  - read/write deassert on the completing edge unless a second access follows immediately: INSTR->DATA or DATA->INSTR is back-to-back with no idle cycle.
- After the last pending access the FSM enters DONE. clk_enable = 1 for exactly one cycle, then IDLE.
- Latency with zero-wait slave:
  - instruction only: 3 cycles IDLE->INSTR->DONE
  - instruction + data: 4 cycles
- read and write are never both 1.
- Wait counter: increments each cycle an access is held by waitrequest, resets on completion.
  - When MAX_WAIT != 0 and counter == MAX_WAIT, bus_error is set to 1.
  - The access is then abandoned: read/write drop, the FSM goes to DONE, and readdata registers are unchanged.
- Inputs are sampled only in IDLE. Changes during INSTR/DATA are ignored.
- Reset mid-transfer: read/write drop immediately (asynchronously); no completion and no clk_enable pulse.

Optional Feature:
- Macro MIPS_ARB_IBUF_EN enables a one-entry instruction buffer (tag = address[31:2], valid bit).
- With the macro: in IDLE, if instr_read, valid, and the tag matches, pi = 0 and instr_readdata already holds the word; no bus fetch occurs.
  - The buffer fills on every completed INSTR access.
  - It is invalidated by a completed data write whose word address equals the tag, by a bus timeout, and by rst.
- Without the macro: every instr_read produces a bus fetch.

Decomposition:
- Package mips_arb_pkg:
  - state enum arb_state_t {IDLE, INSTR, DATA, DONE}
  - BE_WORD = 4'b1111
  - function word_align(addr)
- Sub-module mips_arb_ibuf (tag/valid/hit compare, invalidate port), instantiated only under MIPS_ARB_IBUF_EN.
- FSM and wait counter stay in the top module.

Test Plan:
- Instr-only, waitrequest = 0, instr_address = 0xBFC00002, readdata = 0x24020005 -> address = 0xBFC00000, read for 1 cycle, byteenable = 4'hF, clk_enable pulse on cycle 3, instr_readdata = 0x24020005.
- Instr + data write (addr 0x1004, data 0xDEADBEEF, be 4'b0011), DATA_FIRST = 0 -> INSTR then DATA back-to-back, write = 1 with be = 4'b0011, exactly one clk_enable pulse after 4 cycles.
- Data read with waitrequest high 5 cycles -> address/read held constant for all 5 cycles, data_readdata captured on cycle 6, single clk_enable pulse.
- MAX_WAIT = 8, waitrequest stuck high -> bus_error = 1 after 8 wait cycles, read drops, clk_enable pulses, data_readdata unchanged.
- rst asserted mid-DATA with waitrequest high -> read/write = 0 immediately, no clk_enable pulse, outputs at reset values.
- With MIPS_ARB_IBUF_EN: fetch 0x100 twice -> second fetch issues no bus read; a write to 0x100 between fetches forces a refetch.
